// File: rtl/conv2d_ctrl.sv
// conv2d_ctrl: job sequencer for the 3x3 convolution datapath (kernel load, raster walk, window flags).
// Optional build macro CONV_STRIDE2_EN selects stride-2 window flagging; undefined gives stride 1.
module conv2d_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     kernel_valid,
  input  logic [DATA_W-1:0]        kernel_in,
  output logic                     kernel_ready,
  output logic                     kload_en,
  output logic [3:0]               kload_idx,
  output logic [DATA_W-1:0]        kload_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     lb_shift,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [3:0]    KC_LAST  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_K = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        kc_q, kc_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              kload_en_q, kload_en_d;
  logic [3:0]        kload_idx_q, kload_idx_d;
  logic [DATA_W-1:0] kload_data_q, kload_data_d;
  logic              lb_shift_q, lb_shift_d;
  logic              win_valid_q, win_valid_d;
  logic [RW-1:0]     out_row_q, out_row_d;
  logic [CW-1:0]     out_col_q, out_col_d;
  logic              win_hit_s;
  logic [RW-1:0]     win_row_s;
  logic [CW-1:0]     win_col_s;

  // Window availability and output index for the pixel currently at the raster position
  always_comb begin
    win_hit_s = 1'b0;
    win_row_s = row_q - RW'(2);
    win_col_s = col_q - CW'(2);
`ifdef CONV_STRIDE2_EN
    // (row-2) is even exactly when row is even
    win_hit_s = (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
    win_row_s = (row_q - RW'(2)) >> 1'b1;
    win_col_s = (col_q - CW'(2)) >> 1'b1;
`else
    win_hit_s = (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif
  end

  // Next-state, counter and strobe computation
  always_comb begin
    state_d      = state_q;
    kc_d         = kc_q;
    row_d        = row_q;
    col_d        = col_q;
    kload_en_d   = 1'b0;
    kload_idx_d  = kload_idx_q;
    kload_data_d = kload_data_q;
    lb_shift_d   = 1'b0;
    win_valid_d  = 1'b0;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_K;
          kc_d    = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_K: begin
        if (kernel_valid) begin
          kload_en_d   = 1'b1;
          kload_idx_d  = kc_q;
          kload_data_d = kernel_in;
          if (kc_q == KC_LAST) begin
            state_d = S_RUN;
            kc_d    = 4'd0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            kc_d = kc_q + 4'd1;
          end
        end else begin
          kc_d = kc_q;
        end
      end
      S_RUN: begin
        if (pix_valid) begin
          lb_shift_d = 1'b1;
          if (win_hit_s) begin
            win_valid_d = 1'b1;
            out_row_d   = win_row_s;
            out_col_d   = win_col_s;
          end else begin
            win_valid_d = 1'b0;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
              row_d   = '0;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          lb_shift_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over any handshake in the same cycle, so its strobes and data are dropped
    if (abort) begin
      state_d      = S_IDLE;
      kc_d         = 4'd0;
      row_d        = '0;
      col_d        = '0;
      kload_en_d   = 1'b0;
      kload_idx_d  = kload_idx_q;
      kload_data_d = kload_data_q;
      lb_shift_d   = 1'b0;
      win_valid_d  = 1'b0;
      out_row_d    = out_row_q;
      out_col_d    = out_col_q;
    end else begin
      kc_d = kc_d;
    end
  end

  // State, counters and registered output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      kc_q         <= 4'd0;
      row_q        <= '0;
      col_q        <= '0;
      kload_en_q   <= 1'b0;
      kload_idx_q  <= 4'd0;
      kload_data_q <= '0;
      lb_shift_q   <= 1'b0;
      win_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      kc_q         <= kc_d;
      row_q        <= row_d;
      col_q        <= col_d;
      kload_en_q   <= kload_en_d;
      kload_idx_q  <= kload_idx_d;
      kload_data_q <= kload_data_d;
      lb_shift_q   <= lb_shift_d;
      win_valid_q  <= win_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
    end
  end

  assign kernel_ready = (state_q == S_LOAD_K);
  assign pix_ready    = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign kload_en     = kload_en_q;
  assign kload_idx    = kload_idx_q;
  assign kload_data   = kload_data_q;
  assign lb_shift     = lb_shift_q;
  assign win_valid    = win_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;

endmodule

// File: tb/tb_conv2d_ctrl.sv
// Scoreboard bench for conv2d_ctrl: expected kernel writes and windows are queued as stimulus
// is driven and matched (order and exact cycle) against the registered strobes.
module tb_conv2d_ctrl;
`ifdef CONV_STRIDE2_EN
  localparam int W = 7;
  localparam int H = 5;
  localparam int EXP_WIN = ((W - 1) / 2) * ((H - 1) / 2);
`else
  localparam int W = 5;
  localparam int H = 4;
  localparam int EXP_WIN = (W - 2) * (H - 2);
`endif
  localparam int DW = 32;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          kernel_valid = 1'b0;
  logic [DW-1:0] kernel_in = '0;
  logic          kernel_ready;
  logic          kload_en;
  logic [3:0]    kload_idx;
  logic [DW-1:0] kload_data;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic          lb_shift;
  logic          win_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;

  conv2d_ctrl #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .kernel_valid(kernel_valid), .kernel_in(kernel_in), .kernel_ready(kernel_ready),
    .kload_en(kload_en), .kload_idx(kload_idx), .kload_data(kload_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .lb_shift(lb_shift),
    .win_valid(win_valid), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int a;
    int b;
  } exp_t;

  exp_t kq[$];
  exp_t wq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_kload = 0;
  int n_shift = 0;
  int n_win = 0;
  int n_done = 0;
  int last_row = 0;
  int last_col = 0;

  // Advance one clock, sample at the falling edge and retire scoreboard entries
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (kload_en === 1'b1) begin
      n_kload++;
      total++;
      if (kq.size() == 0) begin
        bad++;
        $display("FAIL kload_unexpected: got idx=%0d data=%0d, required no write", kload_idx, kload_data);
      end else begin
        e = kq.pop_front();
        if (kload_idx !== 4'(e.a) || kload_data !== DW'(e.b) || cyc != e.due) begin
          bad++;
          $display("FAIL kload: got idx=%0d data=%0d cyc=%0d, required idx=%0d data=%0d cyc=%0d",
                   kload_idx, kload_data, cyc, e.a, e.b, e.due);
        end
      end
    end else if (kq.size() > 0 && kq[0].due <= cyc) begin
      total++;
      bad++;
      $display("FAIL kload_missing: got no write at cyc=%0d, required idx=%0d", cyc, kq[0].a);
      void'(kq.pop_front());
    end
    if (win_valid === 1'b1) begin
      n_win++;
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL win_unexpected: got (%0d,%0d), required no window", out_row, out_col);
      end else begin
        e = wq.pop_front();
        last_row = e.a;
        last_col = e.b;
        if (out_row !== RW'(e.a) || out_col !== CW'(e.b) || cyc != e.due) begin
          bad++;
          $display("FAIL window: got (%0d,%0d) cyc=%0d, required (%0d,%0d) cyc=%0d",
                   out_row, out_col, cyc, e.a, e.b, e.due);
        end
      end
    end else begin
      total++;
      if (wq.size() > 0 && wq[0].due <= cyc) begin
        bad++;
        $display("FAIL win_missing: got none at cyc=%0d, required (%0d,%0d)", cyc, wq[0].a, wq[0].b);
        void'(wq.pop_front());
      end else if (out_row !== RW'(last_row) || out_col !== CW'(last_col)) begin
        bad++;
        $display("FAIL win_hold: got (%0d,%0d), required (%0d,%0d)", out_row, out_col, last_row, last_col);
      end
    end
    if (lb_shift === 1'b1) n_shift++;
    if (done === 1'b1) begin
      n_done++;
      total++;
      if (win_valid !== 1'b1) begin
        bad++;
        $display("FAIL done_with_last_window: got win_valid=%b, required 1", win_valid);
      end
    end
  endtask

  task automatic push_kload(input int k);
    exp_t e;
    e.due = cyc + 1;
    e.a = k;
    e.b = k + 1;
    kq.push_back(e);
  endtask

  task automatic push_win(input int r, input int c);
    exp_t e;
    e.due = cyc + 1;
`ifdef CONV_STRIDE2_EN
    if (r >= 2 && c >= 2 && ((r - 2) % 2) == 0 && ((c - 2) % 2) == 0) begin
      e.a = (r - 2) / 2;
      e.b = (c - 2) / 2;
      wq.push_back(e);
    end
`else
    if (r >= 2 && c >= 2) begin
      e.a = r - 2;
      e.b = c - 2;
      wq.push_back(e);
    end
`endif
  endtask

  task automatic run_job(input bit gaps, input bit poke_start, output int done_at);
    int s;
    n_kload = 0; n_shift = 0; n_win = 0; n_done = 0;
    s = cyc;
    start = 1'b1;
    cycle();
    start = 1'b0;
    total++;
    if ({kernel_ready, busy} !== 2'b11) begin
      bad++;
      $display("FAIL start_to_ready: got ready,busy=%b%b, required 11", kernel_ready, busy);
    end
    for (int k = 0; k < 9; k++) begin
      if (gaps) begin kernel_valid = 1'b0; cycle(); end
      kernel_valid = 1'b1;
      kernel_in = DW'(k + 1);
      push_kload(k);
      cycle();
    end
    kernel_valid = 1'b0;
    total++;
    if ({pix_ready, kernel_ready} !== 2'b10) begin
      bad++;
      $display("FAIL pix_ready_rise: got pix,kern=%b%b, required 10", pix_ready, kernel_ready);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) begin pix_valid = 1'b0; cycle(); end
        if (poke_start && r == 1 && c == 1) start = 1'b1;
        pix_valid = 1'b1;
        push_win(r, c);
        cycle();
        start = 1'b0;
      end
    end
    pix_valid = 1'b0;
    done_at = cyc - s;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: got done=%b, required 1", done);
    end
    cycle();
    total++;
    if ({busy, done, pix_ready} !== 3'b000) begin
      bad++;
      $display("FAIL back_to_idle: got busy,done,pix_ready=%b%b%b, required 000", busy, done, pix_ready);
    end
    total++;
    if (n_kload != 9 || n_shift != W * H || n_win != EXP_WIN || n_done != 1 || kq.size() != 0 || wq.size() != 0) begin
      bad++;
      $display("FAIL job_counts: got loads=%0d shifts=%0d wins=%0d dones=%0d, required 9 %0d %0d 1",
               n_kload, n_shift, n_win, n_done, W * H, EXP_WIN);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({kernel_ready, pix_ready, kload_en, kload_idx, kload_data, lb_shift, win_valid,
         out_row, out_col, busy, done} !== '0) begin
      bad++;
      $display("FAIL %s: got ready=%b%b ken=%b idx=%0d data=%0d sh=%b wv=%b row=%0d col=%0d busy=%b done=%b, required all 0",
               tag, kernel_ready, pix_ready, kload_en, kload_idx, kload_data, lb_shift, win_valid,
               out_row, out_col, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset_values");
  endtask

  task automatic test_basic();
    int d;
    run_job(1'b0, 1'b0, d);
    total++;
    if (d != 10 + W * H) begin
      bad++;
      $display("FAIL min_job_length: got %0d, required %0d", d, 10 + W * H);
    end
  endtask

  task automatic test_gaps();
    int d;
    run_job(1'b1, 1'b0, d);
    total++;
    if (d != 19 + 2 * W * H) begin
      bad++;
      $display("FAIL gapped_job_length: got %0d, required %0d", d, 19 + 2 * W * H);
    end
  endtask

  task automatic test_start_in_run();
    int d;
    run_job(1'b0, 1'b1, d);
    total++;
    if (d != 10 + W * H) begin
      bad++;
      $display("FAIL start_in_run_length: got %0d, required %0d", d, 10 + W * H);
    end
  endtask

  task automatic test_abort();
    int d;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      kernel_valid = 1'b1;
      kernel_in = DW'(k + 1);
      push_kload(k);
      cycle();
    end
    n_done = 0;
    kernel_in = DW'(99);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    kernel_valid = 1'b0;
    total++;
    if ({busy, kernel_ready, kload_en} !== 3'b000 || kload_idx !== 4'd2) begin
      bad++;
      $display("FAIL abort_idle: got busy,ready,ken=%b%b%b idx=%0d, required 000 idx=2",
               busy, kernel_ready, kload_en, kload_idx);
    end
    for (int i = 0; i < 3; i++) cycle();
    total++;
    if (n_done != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b, required 0 0", n_done, busy);
    end
    run_job(1'b0, 1'b0, d);
  endtask

  task automatic test_reset_mid();
    int d;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      kernel_valid = 1'b1;
      kernel_in = DW'(k + 1);
      push_kload(k);
      cycle();
    end
    kernel_valid = 1'b0;
    for (int p = 0; p < 11; p++) begin
      pix_valid = 1'b1;
      push_win(p / W, p % W);
      cycle();
    end
    reset = 1'b1;
    last_row = 0;
    last_col = 0;
    cycle();
    reset = 1'b0;
    pix_valid = 1'b0;
    check_reset_outputs("mid_job_reset");
    total++;
    if (kq.size() != 0 || wq.size() != 0) begin
      bad++;
      $display("FAIL reset_pending: got kq=%0d wq=%0d, required 0 0", kq.size(), wq.size());
    end
    kq.delete();
    wq.delete();
    run_job(1'b0, 1'b0, d);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_start_in_run();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
